// File: rtl/irq_ctrl_if.sv
// Host address/command bus shared by the core's memory-mapped peripherals.
// The core drives the master side and irq_ctrl is the slave.
interface irq_ctrl_if #(
  parameter int data_size = 32,
  parameter int padd_size = 24,
  parameter int cmd_size  = 3
);
  logic [padd_size-1:0] host_addr;
  logic [cmd_size-1:0]  host_cmd;
  logic [data_size-1:0] host_datain;
  logic [data_size-1:0] host_dataout;

  modport master (
    output host_addr,
    output host_cmd,
    output host_datain,
    input  host_dataout
  );

  modport slave (
    input  host_addr,
    input  host_cmd,
    input  host_datain,
    output host_dataout
  );
endinterface

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: synchronises the sources, latches them as edge or level,
// masks and prioritises them, and presents one registered request plus source ID to the core.
module irq_ctrl #(
  parameter int                   data_size = 32,
  parameter int                   padd_size = 24,
  parameter int                   cmd_size  = 3,
  parameter int                   irq_src   = 4,
  parameter logic [padd_size-1:0] IRQ_BASE  = 24'h00F000
) (
  input  logic               clk0,
  input  logic               reset,
  input  logic [irq_src-1:0] irq_in,
  irq_ctrl_if.slave          host,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  localparam logic [cmd_size-1:0] CMD_WR = cmd_size'(1);
  localparam logic [cmd_size-1:0] CMD_RD = cmd_size'(2);

  logic [irq_src-1:0]   s1_reg, s2_reg, s3_reg;
  logic [irq_src-1:0]   pend_reg, enable_reg, mode_reg;
  logic                 gie_reg;
  logic [irq_src-1:0]   pend_next;
  logic [irq_src-1:0]   rise, act, wdata;
  logic [3:0]           id_next;
  logic [data_size-1:0] rd_data;
  logic                 sel, wr, rd;
  logic [1:0]           reg_sel;
  logic                 wr_pend, wr_enable, wr_mode, wr_ctrl;
  logic                 unused_bits;

  // Address bits [1:0] and unimplemented data bits carry no meaning here.
  assign unused_bits = ^{host.host_addr[1:0], host.host_datain};

  assign sel       = (host.host_addr[padd_size-1:4] == IRQ_BASE[padd_size-1:4]);
  assign wr        = sel && (host.host_cmd == CMD_WR);
  assign rd        = sel && (host.host_cmd == CMD_RD);
  assign reg_sel   = host.host_addr[3:2];
  assign wr_pend   = wr && (reg_sel == 2'd0);
  assign wr_enable = wr && (reg_sel == 2'd1);
  assign wr_mode   = wr && (reg_sel == 2'd2);
  assign wr_ctrl   = wr && (reg_sel == 2'd3);
  assign wdata     = host.host_datain[irq_src-1:0];

  assign rise = s2_reg & ~s3_reg;
  assign act  = pend_reg & enable_reg;

  // Edge bits: a new rise beats a same-cycle W1C. Level bits follow s2, except that
  // switching a bit to edge mode starts it from a clean, non-pending state.
  generate
    for (genvar gi = 0; gi < irq_src; gi++) begin : g_pend
      assign pend_next[gi] = mode_reg[gi]
                           ? (rise[gi] | (pend_reg[gi] & ~(wr_pend & wdata[gi])))
                           : ((wr_mode & wdata[gi]) ? 1'b0 : s2_reg[gi]);
    end
  endgenerate

  always_comb begin
    id_next = 4'd0;
    for (int i = irq_src - 1; i >= 0; i--) begin
      if (act[i]) id_next = 4'(i);
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0: rd_data[irq_src-1:0] = pend_reg;
      2'd1: rd_data[irq_src-1:0] = enable_reg;
      2'd2: rd_data[irq_src-1:0] = mode_reg;
      default: begin
        rd_data[data_size-1] = gie_reg;
        rd_data[8]           = irq_out;
        rd_data[3:0]         = irq_id;
      end
    endcase
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      s1_reg            <= '0;
      s2_reg            <= '0;
      s3_reg            <= '0;
      pend_reg          <= '0;
      enable_reg        <= '0;
      mode_reg          <= '0;
      gie_reg           <= 1'b0;
      irq_out           <= 1'b0;
      irq_id            <= 4'd0;
      host.host_dataout <= '0;
    end else begin
      s1_reg   <= irq_in;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      pend_reg <= pend_next;
      if (wr_enable) enable_reg <= wdata;
      if (wr_mode)   mode_reg   <= wdata;
      if (wr_ctrl)   gie_reg    <= host.host_datain[data_size-1];
      irq_out           <= gie_reg & (|act);
      irq_id            <= id_next;
      host.host_dataout <= rd ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised scoreboard bench for irq_ctrl: a behavioural model predicts every cycle's outputs,
// a monitor compares them, and directed scenarios add exact-cycle checks on the key corner cases.
module tb_irq_ctrl;
  localparam logic [23:0] IRQ_BASE = 24'h00F000;

  logic       clk0 = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] irq_in = 4'h0;
  logic       irq_out;
  logic [3:0] irq_id;

  irq_ctrl_if #(.data_size(32), .padd_size(24), .cmd_size(3)) bus ();

  irq_ctrl #(
    .data_size(32), .padd_size(24), .cmd_size(3), .irq_src(4), .IRQ_BASE(IRQ_BASE)
  ) dut (
    .clk0   (clk0),
    .reset  (reset),
    .irq_in (irq_in),
    .host   (bus),
    .irq_out(irq_out),
    .irq_id (irq_id)
  );

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: registers as the programmer sees them, plus the
  // sampled input history (front = sample taken at the most recent edge).
  logic [3:0]  m_pend = 4'h0, m_en = 4'h0, m_mode = 4'h0, m_id = 4'h0;
  logic        m_gie = 1'b0, m_out = 1'b0;
  logic [3:0]  hist [$] = '{4'h0, 4'h0, 4'h0};
  logic [4:0]  irq_q [$];
  logic [31:0] rd_q [$];

  task automatic model_step();
    logic [3:0]  act, d, dp;
    logic        sel, wr, rd, nout;
    logic [1:0]  r;
    logic [31:0] rdv;
    logic [3:0]  nid;
    if (!reset) begin
      m_pend = 4'h0; m_en = 4'h0; m_mode = 4'h0; m_gie = 1'b0;
      m_out = 1'b0; m_id = 4'h0;
      hist = '{4'h0, 4'h0, 4'h0};
      irq_q.push_back(5'h00);
      rd_q.push_back(32'h0);
      return;
    end
    sel = (bus.host_addr[23:4] == IRQ_BASE[23:4]);
    wr  = sel && (bus.host_cmd == 3'b001);
    rd  = sel && (bus.host_cmd == 3'b010);
    r   = bus.host_addr[3:2];
    act = m_pend & m_en;
    rdv = 32'h0;
    if (rd) begin
      case (r)
        2'd0:    rdv = {28'h0, m_pend};
        2'd1:    rdv = {28'h0, m_en};
        2'd2:    rdv = {28'h0, m_mode};
        default: rdv = {m_gie, 22'h0, m_out, 4'h0, m_id};
      endcase
    end
    nout = m_gie && (act != 4'h0);
    nid  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (act[i]) begin
        nid = 4'(i);
        break;
      end
    end
    // The input as seen two sampling edges ago, and the one before that.
    d  = hist[1];
    dp = hist[2];
    for (int i = 0; i < 4; i++) begin
      if (m_mode[i]) begin
        if (d[i] && !dp[i])                                   m_pend[i] = 1'b1;
        else if (wr && r == 2'd0 && bus.host_datain[i])       m_pend[i] = 1'b0;
      end else begin
        if (wr && r == 2'd2 && bus.host_datain[i])            m_pend[i] = 1'b0;
        else                                                  m_pend[i] = d[i];
      end
    end
    if (wr && r == 2'd1) m_en   = bus.host_datain[3:0];
    if (wr && r == 2'd2) m_mode = bus.host_datain[3:0];
    if (wr && r == 2'd3) m_gie  = bus.host_datain[31];
    m_out = nout;
    m_id  = nid;
    hist.push_front(irq_in);
    void'(hist.pop_back());
    irq_q.push_back({nout, nid});
    rd_q.push_back(rdv);
  endtask

  // Monitor: predict at the active edge, compare on the following falling edge.
  initial begin
    logic [4:0]  e;
    logic [31:0] ed;
    forever begin
      @(posedge clk0);
      model_step();
      @(negedge clk0);
      if (irq_q.size() > 0) begin
        e = irq_q.pop_front();
        check("irq_out", {31'h0, irq_out}, {31'h0, e[4]});
        check("irq_id", {28'h0, irq_id}, {28'h0, e[3:0]});
      end
      if (rd_q.size() > 0) begin
        ed = rd_q.pop_front();
        check("host_dataout", bus.host_dataout, ed);
      end
    end
  end

  // One host command lasting exactly one cycle; called on a falling edge.
  task automatic op(input logic [2:0] cmd, input logic [23:0] addr, input logic [31:0] data);
    bus.host_cmd    = cmd;
    bus.host_addr   = addr;
    bus.host_datain = data;
    @(negedge clk0);
    bus.host_cmd    = 3'b000;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data);
    op(3'b001, IRQ_BASE | 24'(off), data);
  endtask

  task automatic rd(input logic [3:0] off);
    op(3'b010, IRQ_BASE | 24'(off), 32'h0);
  endtask

  initial begin
    logic [23:0] a;
    logic [2:0]  c;
    int          pick;
    bus.host_cmd = 3'b000; bus.host_addr = 24'h0; bus.host_datain = 32'h0;

    // Reset and readback.
    repeat (3) @(negedge clk0);
    reset = 1'b1;
    @(negedge clk0);
    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);
    check("reset_ctrl_read", bus.host_dataout, 32'h0);
    check("reset_irq_out", {31'h0, irq_out}, 32'h0);

    // Single edge pulse on source 2.
    wr(4'h4, 32'h4); wr(4'h8, 32'h4); wr(4'hC, 32'h8000_0000);
    repeat (2) @(negedge clk0);
    irq_in = 4'b0100;
    @(negedge clk0);
    irq_in = 4'b0000;
    repeat (2) @(negedge clk0);
    check("edge_not_early", {31'h0, irq_out}, 32'h0);
    @(negedge clk0);
    check("edge_irq_out", {31'h0, irq_out}, 32'h1);
    check("edge_irq_id", {28'h0, irq_id}, 32'h2);
    rd(4'h0);
    check("edge_pend_read", bus.host_dataout, 32'h4);
    wr(4'h0, 32'h4);
    @(negedge clk0);
    check("w1c_irq_drop", {31'h0, irq_out}, 32'h0);

    // Priority and masking in level mode.
    wr(4'h8, 32'h0);
    irq_in = 4'b1010;
    wr(4'h4, 32'hF);
    repeat (5) @(negedge clk0);
    check("prio_id_1", {28'h0, irq_id}, 32'h1);
    wr(4'h4, 32'h8);
    @(negedge clk0);
    check("mask_id_3", {28'h0, irq_id}, 32'h3);
    wr(4'hC, 32'h0);
    @(negedge clk0);
    check("gie_off_irq_out", {31'h0, irq_out}, 32'h0);
    rd(4'h0);
    check("gie_off_pend", bus.host_dataout, 32'hA);
    rd(4'hC);
    check("ctrl_read", bus.host_dataout, 32'h0000_0003);

    // Set/clear collision on bit 0.
    irq_in = 4'b0000;
    wr(4'h8, 32'h1); wr(4'h4, 32'h1); wr(4'hC, 32'h8000_0000);
    repeat (4) @(negedge clk0);
    irq_in = 4'b0001;
    @(negedge clk0);
    irq_in = 4'b0000;
    repeat (4) @(negedge clk0);
    check("coll_first_req", {31'h0, irq_out}, 32'h1);
    irq_in = 4'b0001;
    @(negedge clk0);
    irq_in = 4'b0000;
    @(negedge clk0);
    wr(4'h0, 32'h1);
    check("coll_out_a", {31'h0, irq_out}, 32'h1);
    @(negedge clk0);
    check("coll_out_b", {31'h0, irq_out}, 32'h1);
    rd(4'h0);
    check("coll_pend", bus.host_dataout, 32'h1);

    // W1C has no effect on a level bit; deassertion clears PEND three edges later.
    irq_in = 4'b0010;
    wr(4'h8, 32'h0); wr(4'h4, 32'h2);
    repeat (4) @(negedge clk0);
    wr(4'h0, 32'h2);
    rd(4'h0);
    check("level_w1c_ignored", bus.host_dataout, 32'h2);
    irq_in = 4'b0000;
    repeat (2) @(negedge clk0);
    rd(4'h0);
    check("level_pend_still", bus.host_dataout, 32'h2);
    rd(4'h0);
    check("level_pend_cleared", bus.host_dataout, 32'h0);

    // Asynchronous reset while a request is active.
    irq_in = 4'b0010;
    repeat (4) @(negedge clk0);
    check("pre_reset_irq_out", {31'h0, irq_out}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rst_irq_out", {31'h0, irq_out}, 32'h0);
    check("rst_pend", {28'h0, dut.pend_reg}, 32'h0);
    check("rst_enable", {28'h0, dut.enable_reg}, 32'h0);
    repeat (2) @(negedge clk0);
    #2 reset = 1'b1;
    repeat (8) @(negedge clk0);
    check("post_reset_no_req", {31'h0, irq_out}, 32'h0);
    rd(4'h4);
    check("post_reset_enable", bus.host_dataout, 32'h0);

    // Randomised traffic checked by the scoreboard.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'(1 << $urandom_range(0, 3));
      a = IRQ_BASE | 24'($urandom_range(0, 15));
      if ($urandom_range(0, 6) == 0) a = a ^ 24'(1 << $urandom_range(4, 23));
      pick = int'($urandom_range(0, 9));
      if (pick < 4)      c = 3'b001;
      else if (pick < 7) c = 3'b010;
      else if (pick < 8) c = 3'b000;
      else               c = 3'($urandom_range(3, 7));
      op(c, a, $urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk0);
        #2 reset = 1'b1;
        @(negedge clk0);
      end
    end
    repeat (3) @(negedge clk0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
